conv_sched: RTL and testbench



---
 rtl/conv_pkg.sv | 16 +
 rtl/tap_addr_gen.sv | 32 +++
 rtl/conv_sched.sv | 189 ++++++++++++++++++
 tb/tb_conv_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3, four-lane convolution sequencer.
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  localparam int unsigned K      = 3;
  localparam int unsigned NTAP   = K * K;
  localparam int unsigned NLANE  = 4;
  localparam int unsigned TAP_W  = 4;
  localparam int unsigned LANE_W = 2;

endpackage

// File: rtl/tap_addr_gen.sv
// Per-lane SRAM address for one window tap; flags taps that fall outside the image.
module tap_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned YW     = 8,
  parameter int unsigned XW     = 8
) (
  input  logic [YW-1:0]     y_i,
  input  logic [XW-1:0]     x0_i,
  input  logic [TAP_W-1:0]  t_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              en_o,
  output logic              pad_o
);

  int r;
  int c;

  always_comb begin
    // Window is centred on the output pixel, hence the -1 offsets.
    r      = int'(y_i) + int'(t_i) / int'(K) - 1;
    c      = int'(x0_i) + int'(lane_i) + int'(t_i) % int'(K) - 1;
    pad_o  = (r < 0) || (r >= int'(IMG_H)) || (c < 0) || (c >= int'(IMG_W));
    en_o   = !pad_o;
    addr_o = pad_o ? '0 : ADDR_W'(r * int'(IMG_W) + c);
  end

endmodule

// File: rtl/conv_sched.sv
// Coefficient loader and frame sweeper for the four-lane 3x3 convolution datapath.
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 256,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fc_valid_i,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              coef_we_o,
  output logic [3:0]        coef_idx_o,
  output logic              coef_ready_o,
  output logic [ADDR_W-1:0] addr0_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic [ADDR_W-1:0] addr3_o,
  output logic              en0_o,
  output logic              en1_o,
  output logic              en2_o,
  output logic              en3_o,
  output logic              wen0_o,
  output logic              wen1_o,
  output logic              wen2_o,
  output logic              wen3_o,
  output logic              tap_valid_o,
  output logic [3:0]        tap_idx_o,
  output logic [3:0]        tap_zero_o,
  output logic              acc_clr_o,
  output logic              pix_done_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [YW-1:0]    YLast = YW'(IMG_H - 1);
  localparam logic [XW-1:0]    XLast = XW'(IMG_W - NLANE);
  localparam logic [TAP_W-1:0] TLast = TAP_W'(NTAP - 1);

  state_e           state_q, state_d;
  logic [YW-1:0]    y_q, y_d;
  logic [XW-1:0]    x0_q, x0_d;
  logic [TAP_W-1:0] t_q, t_d;
  logic [TAP_W-1:0] cnt_q, cnt_d;
  logic             coef_ready_q, coef_ready_d;

  logic             tap_valid_q, tap_valid_d;
  logic [TAP_W-1:0] tap_idx_q, tap_idx_d;
  logic [NLANE-1:0] tap_zero_q, tap_zero_d;
  logic             acc_clr_q, acc_clr_d;
  logic             pix_done_q, pix_done_d;

  logic             issue;
  logic [ADDR_W-1:0] lane_addr [NLANE];
  logic [NLANE-1:0]  lane_en;
  logic [NLANE-1:0]  lane_pad;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    tap_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .ADDR_W(ADDR_W),
      .YW    (YW),
      .XW    (XW)
    ) u_tap_addr_gen (
      .y_i   (y_q),
      .x0_i  (x0_q),
      .t_i   (t_q),
      .lane_i(LANE_W'(i)),
      .addr_o(lane_addr[i]),
      .en_o  (lane_en[i]),
      .pad_o (lane_pad[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    x0_d         = x0_q;
    t_d          = t_q;
    cnt_d        = cnt_q;
    coef_ready_d = coef_ready_q;
    coef_we_o    = 1'b0;
    issue        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A coefficient write takes priority over a coincident start.
        if (fc_valid_i) begin
          coef_we_o = 1'b1;
          if (cnt_q == TLast) begin
            cnt_d        = '0;
            coef_ready_d = 1'b1;
          end else begin
            cnt_d        = cnt_q + 1'b1;
            coef_ready_d = 1'b0;
          end
        end else if (start_i && coef_ready_q) begin
          state_d = StRun;
          y_d     = '0;
          x0_d    = '0;
          t_d     = '0;
        end
      end
      StRun: begin
        if (!hold_i) begin
          issue = 1'b1;
          if (t_q == TLast) begin
            t_d = '0;
            if (x0_q == XLast) begin
              x0_d = '0;
              if (y_q == YLast) begin
                state_d = StDrain;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x0_d = x0_q + XW'(NLANE);
            end
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Tap side-band is delayed one cycle to line up with the SRAM read data.
  always_comb begin
    tap_valid_d = issue;
    tap_idx_d   = issue ? t_q : '0;
    tap_zero_d  = issue ? lane_pad : '0;
    acc_clr_d   = issue && (t_q == '0);
    pix_done_d  = issue && (t_q == TLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      y_q          <= '0;
      x0_q         <= '0;
      t_q          <= '0;
      cnt_q        <= '0;
      coef_ready_q <= 1'b0;
      tap_valid_q  <= 1'b0;
      tap_idx_q    <= '0;
      tap_zero_q   <= '0;
      acc_clr_q    <= 1'b0;
      pix_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      y_q          <= y_d;
      x0_q         <= x0_d;
      t_q          <= t_d;
      cnt_q        <= cnt_d;
      coef_ready_q <= coef_ready_d;
      tap_valid_q  <= tap_valid_d;
      tap_idx_q    <= tap_idx_d;
      tap_zero_q   <= tap_zero_d;
      acc_clr_q    <= acc_clr_d;
      pix_done_q   <= pix_done_d;
    end
  end

  always_comb begin
    addr0_o = (state_q == StRun) ? lane_addr[0] : '0;
    addr1_o = (state_q == StRun) ? lane_addr[1] : '0;
    addr2_o = (state_q == StRun) ? lane_addr[2] : '0;
    addr3_o = (state_q == StRun) ? lane_addr[3] : '0;
    {en3_o, en2_o, en1_o, en0_o}     = issue ? lane_en : '0;
    {wen3_o, wen2_o, wen1_o, wen0_o} = '0;
    coef_idx_o   = coef_we_o ? cnt_q : '0;
    coef_ready_o = coef_ready_q;
    tap_valid_o  = tap_valid_q;
    tap_idx_o    = tap_idx_q;
    tap_zero_o   = tap_zero_q;
    acc_clr_o    = acc_clr_q;
    pix_done_o   = pix_done_q;
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDrain);
  end

endmodule

// File: tb/tb_conv_sched.sv
// Directed + randomised-hold bench for conv_sched on an 8x4 image.
module tb_conv_sched;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NG = W / 4;
  localparam int NT = 9 * NG * H;

  logic clk = 1'b0;
  logic rst_n;
  logic fc_valid_i, start_i, hold_i;
  logic coef_we_o, coef_ready_o;
  logic [3:0] coef_idx_o;
  logic [15:0] addr0_o, addr1_o, addr2_o, addr3_o;
  logic en0_o, en1_o, en2_o, en3_o;
  logic wen0_o, wen1_o, wen2_o, wen3_o;
  logic tap_valid_o, acc_clr_o, pix_done_o, busy_o, done_o;
  logic [3:0] tap_idx_o, tap_zero_o;

  logic [15:0] addr_v [4];
  logic [3:0]  en_v, wen_v;

  int checks   = 0;
  int failures = 0;

  assign addr_v[0] = addr0_o;
  assign addr_v[1] = addr1_o;
  assign addr_v[2] = addr2_o;
  assign addr_v[3] = addr3_o;
  assign en_v  = {en3_o, en2_o, en1_o, en0_o};
  assign wen_v = {wen3_o, wen2_o, wen1_o, wen0_o};

  always #5 clk = ~clk;

  conv_sched #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fc_valid_i  (fc_valid_i),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .coef_we_o   (coef_we_o),
    .coef_idx_o  (coef_idx_o),
    .coef_ready_o(coef_ready_o),
    .addr0_o     (addr0_o),
    .addr1_o     (addr1_o),
    .addr2_o     (addr2_o),
    .addr3_o     (addr3_o),
    .en0_o       (en0_o),
    .en1_o       (en1_o),
    .en2_o       (en2_o),
    .en3_o       (en3_o),
    .wen0_o      (wen0_o),
    .wen1_o      (wen1_o),
    .wen2_o      (wen2_o),
    .wen3_o      (wen3_o),
    .tap_valid_o (tap_valid_o),
    .tap_idx_o   (tap_idx_o),
    .tap_zero_o  (tap_zero_o),
    .acc_clr_o   (acc_clr_o),
    .pix_done_o  (pix_done_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: output pixel sweep index -> (row, group, tap) -> window position.
  function automatic bit m_pad(input int idx, input int lane);
    int y, x0, t, r, c;
    y  = idx / (9 * NG);
    x0 = ((idx / 9) % NG) * 4;
    t  = idx % 9;
    r  = y + t / 3 - 1;
    c  = x0 + lane + t % 3 - 1;
    return (r < 0) || (r >= H) || (c < 0) || (c >= W);
  endfunction

  function automatic int m_addr(input int idx, input int lane);
    int y, x0, t;
    y  = idx / (9 * NG);
    x0 = ((idx / 9) % NG) * 4;
    t  = idx % 9;
    if (m_pad(idx, lane)) return 0;
    return (y + t / 3 - 1) * W + (x0 + lane + t % 3 - 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {coef_we_o, coef_idx_o, coef_ready_o, en_v, wen_v, tap_valid_o,
                        tap_idx_o, tap_zero_o, acc_clr_o, pix_done_o, busy_o, done_o}, '0);
    chk({tag, "_addr"}, {addr3_o, addr2_o, addr1_o, addr0_o}, '0);
  endtask

  task automatic load_coefs(input int from);
    for (int k = from; k < 9; k++) begin
      fc_valid_i = 1'b1;
      #1;
      chk("coef_we", coef_we_o, 1);
      chk("coef_idx", coef_idx_o, k);
      if (k > from) chk("coef_ready_loading", coef_ready_o, 0);
      tick();
    end
    fc_valid_i = 1'b0;
    #1;
    chk("coef_we_idle", coef_we_o, 0);
    chk("coef_ready_after_9", coef_ready_o, 1);
  endtask

  // mode 0: no hold, 1: 3-cycle hold at tap hold_at, 2: random holds.
  task automatic run_frame(input int mode, input int hold_at);
    int idx, cyc, nhold, nvalid, prev_idx;
    bit prev_issue, h, drained;
    logic [3:0] exp_en, exp_zero;
    idx = 0; cyc = 0; nhold = 0; nvalid = 0; prev_idx = 0;
    prev_issue = 0; drained = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (!drained && cyc < 400) begin
      cyc++;
      if (idx < NT) begin
        case (mode)
          1:       h = (idx == hold_at) && (nhold < 3);
          2:       h = ($urandom_range(0, 3) == 0);
          default: h = 1'b0;
        endcase
      end else begin
        h = 1'($urandom_range(0, 1));
      end
      hold_i = h;
      #1;
      chk("tap_valid", tap_valid_o, prev_issue);
      if (tap_valid_o === 1'b1) nvalid++;
      if (prev_issue) begin
        for (int l = 0; l < 4; l++) exp_zero[l] = m_pad(prev_idx, l);
        chk("tap_idx", tap_idx_o, prev_idx % 9);
        chk("tap_zero", tap_zero_o, exp_zero);
        chk("acc_clr", acc_clr_o, (prev_idx % 9) == 0);
        chk("pix_done", pix_done_o, (prev_idx % 9) == 8);
        if (prev_idx == 0) begin
          chk("corner_t0_zero", tap_zero_o, 4'hF);
          chk("corner_t0_clr", acc_clr_o, 1);
        end
      end else begin
        chk("side_idle", {acc_clr_o, pix_done_o}, 0);
      end
      chk("wen", wen_v, 0);
      if (idx == NT) begin
        chk("done", done_o, 1);
        chk("drain_busy", busy_o, 1);
        chk("drain_en", en_v, 0);
        chk("done_cycle", cyc, NT + 1 + nhold);
        drained = 1;
      end else begin
        chk("busy", busy_o, 1);
        chk("done_early", done_o, 0);
        for (int l = 0; l < 4; l++) exp_en[l] = !m_pad(idx, l);
        chk("en", en_v, h ? 4'h0 : exp_en);
        for (int l = 0; l < 4; l++) chk("addr", addr_v[l], m_addr(idx, l));
        if (idx == 0) chk("corner_t0_en", en_v, 4'h0);
        if (idx == 4) chk("corner_t4_addr", {addr3_o, addr2_o, addr1_o, addr0_o},
                          {16'd3, 16'd2, 16'd1, 16'd0});
        if (idx == 5) chk("corner_t5_addr3", addr3_o, 4);
        if (idx == 27) chk("edge_t0_addr", {addr3_o, addr2_o, addr1_o, addr0_o},
                           {16'd6, 16'd5, 16'd4, 16'd3});
        if (idx == 35) begin
          chk("edge_t8_addr", {addr2_o, addr1_o, addr0_o}, {16'd23, 16'd22, 16'd21});
          chk("edge_t8_en3", en3_o, 0);
        end
        if (h) nhold++;
        prev_issue = !h;
        prev_idx   = idx;
        if (!h) idx++;
      end
      tick();
    end
    hold_i = 1'b0;
    if (!drained) chk("frame_timeout", 0, 1);
    chk("valid_count", nvalid, NT);
    chk("idle_after", {busy_o, done_o, tap_valid_o, en_v}, 0);
    chk("ready_kept", coef_ready_o, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    fc_valid_i = 1'b0;
    start_i = 1'b0;
    hold_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) begin
      chk("start_no_coef", busy_o, 0);
      tick();
    end

    load_coefs(0);
    tick();
    fc_valid_i = 1'b1;
    #1;
    chk("reload_idx", coef_idx_o, 0);
    chk("reload_we", coef_we_o, 1);
    tick();
    fc_valid_i = 1'b0;
    #1;
    chk("reload_ready_clr", coef_ready_o, 0);
    load_coefs(1);

    // Coincident start and coefficient write: the write wins.
    tick();
    fc_valid_i = 1'b1;
    start_i = 1'b1;
    #1;
    chk("collide_we", coef_we_o, 1);
    chk("collide_idx", coef_idx_o, 0);
    tick();
    fc_valid_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("collide_busy", busy_o, 0);
    chk("collide_ready", coef_ready_o, 0);
    load_coefs(1);

    tick();
    run_frame(0, 0);
    run_frame(1, 20);

    // Reset during the sweep while tap 20 is being issued.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    chk("pre_reset_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", coef_ready_o, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("post_reset_start", busy_o, 0);
    tick();
    load_coefs(0);
    tick();
    run_frame(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
